// File: rtl/md_sequencer_pkg.sv
// md_sequencer_pkg: shared state encoding, exception codes and mul/div decode constants
package md_sequencer_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;
    localparam logic [31:0] MUL_EXC = 32'd4;
    localparam logic [31:0] DIV_EXC = 32'd5;
    localparam logic [4:0] OPC_ALU = 5'b00000;
    localparam logic [4:0] ALUOP_MUL = 5'b00110;
    localparam logic [4:0] ALUOP_DIV = 5'b00111;
    function automatic logic is_md(input logic [4:0] opc, input logic [4:0] aluop);
        return opc == OPC_ALU && (aluop == ALUOP_MUL || aluop == ALUOP_DIV);
    endfunction
endpackage

// File: rtl/md_timeout_counter.sv
// md_timeout_counter: 6-bit busy-cycle counter (clk/rst, clr, en in; cnt, term at TIMEOUT-1 out)
module md_timeout_counter
    import md_sequencer_pkg::*;
#(
    parameter int TIMEOUT = 40
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       clr,
    input  logic       en,
    output logic [5:0] cnt,
    output logic       term
);
    logic [5:0] cnt_q, cnt_d;
    always_comb cnt_d = clr ? 6'd0 : en ? cnt_q + 6'd1 : cnt_q;
    always_ff @(posedge clock) cnt_q <= reset ? 6'd0 : cnt_d;
    assign cnt = cnt_q;
    assign term = cnt_q == 6'(TIMEOUT - 1);
endmodule

// File: rtl/md_sequencer.sv
// md_sequencer: issues mul/div to the unit, stalls X while busy, arbitrates the result onto the write port (issue_*, md_* in; md_a/b, ctrl_*, stall, wb_* out)
module md_sequencer
    import md_sequencer_pkg::*;
#(
    parameter int TIMEOUT     = 40,
    parameter int RSTATUS_REG = 30
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        issue_valid,
    input  logic        issue_is_div,
    input  logic [31:0] issue_a,
    input  logic [31:0] issue_b,
    input  logic [4:0]  issue_rd,
    input  logic [31:0] md_result,
    input  logic        md_exception,
    input  logic        md_ready,
    input  logic        wb_grant,
    output logic [31:0] md_a,
    output logic [31:0] md_b,
    output logic        ctrl_MULT,
    output logic        ctrl_DIV,
    output logic        stall,
    output logic        wb_valid,
    output logic [4:0]  wb_reg,
    output logic [31:0] wb_data
);
    state_t      state_q, state_d;
    logic [31:0] md_a_q, md_a_d, md_b_q, md_b_d, wb_data_q, wb_data_d;
    logic [4:0]  rd_q, rd_d, wb_reg_q, wb_reg_d;
    logic        div_q, div_d, mult_q, mult_d, dv_q, dv_d, wb_valid_q, wb_valid_d;
    logic [5:0]  cnt;
    logic        term, exc;
    md_timeout_counter #(.TIMEOUT(TIMEOUT)) u_cnt (
        .clock(clock),
        .reset(reset),
        .clr(state_q != BUSY),
        .en(state_q == BUSY),
        .cnt(cnt),
        .term(term)
    );
    // a timeout is reported exactly like a unit exception; ready wins a tie with the timeout
    assign exc = md_ready ? md_exception : 1'b1;
    always_comb begin
        state_d = state_q;
        md_a_d = md_a_q;
        md_b_d = md_b_q;
        rd_d = rd_q;
        div_d = div_q;
        mult_d = 1'b0;
        dv_d = 1'b0;
        wb_valid_d = wb_valid_q;
        wb_reg_d = wb_reg_q;
        wb_data_d = wb_data_q;
        case (state_q)
            IDLE: if (issue_valid) begin
                state_d = BUSY;
                md_a_d = issue_a;
                md_b_d = issue_b;
                rd_d = issue_rd;
                div_d = issue_is_div;
                mult_d = !issue_is_div;
                dv_d = issue_is_div;
            end
            BUSY: if ((md_ready && cnt != 6'd0) || term) begin
                state_d = DONE;
                wb_valid_d = 1'b1;
                wb_reg_d = exc ? 5'(RSTATUS_REG) : rd_q;
                wb_data_d = exc ? (div_q ? DIV_EXC : MUL_EXC) : md_result;
            end
            DONE: if (wb_grant) begin
                state_d = IDLE;
                wb_valid_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            md_a_q <= '0;
            md_b_q <= '0;
            rd_q <= '0;
            div_q <= 1'b0;
            mult_q <= 1'b0;
            dv_q <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_reg_q <= '0;
            wb_data_q <= '0;
        end else begin
            state_q <= state_d;
            md_a_q <= md_a_d;
            md_b_q <= md_b_d;
            rd_q <= rd_d;
            div_q <= div_d;
            mult_q <= mult_d;
            dv_q <= dv_d;
            wb_valid_q <= wb_valid_d;
            wb_reg_q <= wb_reg_d;
            wb_data_q <= wb_data_d;
        end
    end
    assign md_a = md_a_q;
    assign md_b = md_b_q;
    assign ctrl_MULT = mult_q;
    assign ctrl_DIV = dv_q;
    assign stall = (issue_valid && state_q == IDLE) || state_q != IDLE;
    assign wb_valid = wb_valid_q;
    assign wb_reg = wb_reg_q;
    assign wb_data = wb_data_q;
endmodule

// File: tb/tb_md_sequencer.sv
// tb_md_sequencer: directed plus randomized transactions against a transaction-level timing model
module tb_md_sequencer;
    localparam int T = 8;
    logic        clock = 1'b0, reset = 1'b1;
    logic        issue_valid = 1'b0, issue_is_div = 1'b0;
    logic [31:0] issue_a = '0, issue_b = '0, md_result = '0;
    logic [4:0]  issue_rd = '0;
    logic        md_exception = 1'b0, md_ready = 1'b0, wb_grant = 1'b0;
    logic [31:0] md_a, md_b, wb_data;
    logic        ctrl_MULT, ctrl_DIV, stall, wb_valid;
    logic [4:0]  wb_reg;
    int          n_vec = 0, n_err = 0;
    always #5 clock = ~clock;
    md_sequencer #(.TIMEOUT(T), .RSTATUS_REG(30)) dut (
        .clock(clock),
        .reset(reset),
        .issue_valid(issue_valid),
        .issue_is_div(issue_is_div),
        .issue_a(issue_a),
        .issue_b(issue_b),
        .issue_rd(issue_rd),
        .md_result(md_result),
        .md_exception(md_exception),
        .md_ready(md_ready),
        .wb_grant(wb_grant),
        .md_a(md_a),
        .md_b(md_b),
        .ctrl_MULT(ctrl_MULT),
        .ctrl_DIV(ctrl_DIV),
        .stall(stall),
        .wb_valid(wb_valid),
        .wb_reg(wb_reg),
        .wb_data(wb_data)
    );
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask
    task automatic chk_zero(input string tag);
        chk({tag, ".md_a"}, md_a, 0);
        chk({tag, ".md_b"}, md_b, 0);
        chk({tag, ".mult"}, ctrl_MULT, 0);
        chk({tag, ".div"}, ctrl_DIV, 0);
        chk({tag, ".stall"}, stall, 0);
        chk({tag, ".wb_valid"}, wb_valid, 0);
        chk({tag, ".wb_reg"}, wb_reg, 0);
        chk({tag, ".wb_data"}, wb_data, 0);
    endtask
    // d: ready delay after the pulse cycle; early: extra ready in the pulse cycle; g: grant-denied DONE cycles
    task automatic run_op(input bit div, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                          input int d, input bit early, input bit exc, input int g);
        bit          hit, xe;
        int          k, last;
        logic [31:0] res, edat;
        logic [4:0]  erg;
        hit = d >= 1 && d <= T - 1;
        k = hit ? d : T - 1;
        xe = hit ? exc : 1'b1;
        res = div ? (b != 0 ? a / b : 32'hdead_beef) : a * b;
        erg = xe ? 5'd30 : rd;
        edat = xe ? (div ? 32'd5 : 32'd4) : res;
        last = k + g + 3;
        for (int c = 0; c <= last; c++) begin
            issue_valid = c < last;
            issue_is_div = c == 0 ? div : 1'($urandom);
            issue_a = c == 0 ? a : $urandom;
            issue_b = c == 0 ? b : $urandom;
            issue_rd = c == 0 ? rd : 5'($urandom);
            md_ready = (early && c == 1) || c == 1 + d || (c >= k + 2 && $urandom_range(0, 1) == 1);
            md_result = c == 1 + d ? res : $urandom;
            md_exception = c == 1 + d ? exc : (early && c == 1) ? 1'b1 : 1'($urandom);
            wb_grant = (c >= k + 2 && c < k + 2 + g) ? 1'b0 : c == k + 2 + g ? 1'b1 : 1'($urandom);
            @(negedge clock);
            chk("stall", stall, c < last);
            chk("ctrl_MULT", ctrl_MULT, c == 1 && !div);
            chk("ctrl_DIV", ctrl_DIV, c == 1 && div);
            chk("wb_valid", wb_valid, c >= k + 2 && c <= k + 2 + g);
            if (c >= 1) begin
                chk("md_a", md_a, a);
                chk("md_b", md_b, b);
            end
            if (c >= k + 2 && c <= k + 2 + g) begin
                chk("wb_reg", wb_reg, erg);
                chk("wb_data", wb_data, edat);
            end
            @(posedge clock);
            #1;
        end
    endtask
    initial begin
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk_zero("reset");
        @(posedge clock);
        #1;
        reset = 1'b0;
        run_op(1'b0, 32'd7, 32'd6, 5'd3, 5, 1'b0, 1'b0, 0);
        run_op(1'b1, 32'd10, 32'd0, 5'd9, 3, 1'b0, 1'b1, 0);
        run_op(1'b0, 32'd123, 32'd45, 5'd4, 99, 1'b0, 1'b0, 0);
        run_op(1'b1, 32'd1000, 32'd7, 5'd12, 2, 1'b0, 1'b0, 3);
        run_op(1'b1, 32'd81, 32'd9, 5'd17, T - 1, 1'b1, 1'b0, 0);
        for (int c = 0; c < 9; c++) begin
            issue_valid = c < 4;
            issue_is_div = 1'b0;
            issue_a = 32'd5;
            issue_b = 32'd8;
            issue_rd = 5'd6;
            reset = c == 3;
            md_ready = c >= 4;
            md_exception = 1'($urandom);
            md_result = $urandom;
            wb_grant = 1'($urandom);
            if (c >= 4) issue_valid = 1'b0;
            @(negedge clock);
            if (c == 1) chk("rst.pulse", ctrl_MULT, 1);
            if (c >= 4) chk_zero("midreset");
            @(posedge clock);
            #1;
        end
        reset = 1'b0;
        run_op(1'b0, 32'hffff_0001, 32'd3, 5'd21, 4, 1'b0, 1'b0, 1);
        repeat (40)
            run_op(1'($urandom), $urandom, $urandom_range(0, 20), 5'($urandom), $urandom_range(0, T + 2),
                   1'($urandom), 1'($urandom), $urandom_range(0, 3));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
